// File: rtl/mem_wb_pkg.sv
// ============================================================================
//  mem_wb_pkg : shared types and constants for the MEM/WB stage
//  Rev 1.0
// ============================================================================
`default_nettype none

package mem_wb_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WB    = 2'd1,
    S_MREQ  = 2'd2,
    S_MRESP = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
//  lsu_align : combinational store lane alignment and load data extraction
//  Rev 1.0
// ============================================================================
`default_nettype none

module lsu_align
  import mem_wb_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [1:0]      addr_lo_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] store_data_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [3:0]      we_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] ldata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  // Narrow stores replicate the datum across all lanes; the strobes pick the lane.
  always_comb begin
    we_o    = 4'hF;
    wdata_o = store_data_i;
    case (funct3_i)
      F3_B: begin
        we_o    = 4'b0001 << addr_lo_i;
        wdata_o = {(XLEN/8){store_data_i[7:0]}};
      end
      F3_H: begin
        we_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {(XLEN/16){store_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ldata_o = rdata_i;
    case (funct3_i)
      F3_B:    ldata_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_BU:   ldata_o = {{(XLEN-8){1'b0}}, byte_sel};
      F3_H:    ldata_o = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_HU:   ldata_o = {{(XLEN-16){1'b0}}, half_sel};
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_wb_stage.sv
// ============================================================================
//  mem_wb_stage : one-entry MEM/WB stage with data-memory access and WB bus
//  Rev 1.0
// ============================================================================
`default_nettype none

module mem_wb_stage
  import mem_wb_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CSR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_result,
  input  logic [XLEN-1:0]  ex_store_data,
  input  logic             ex_is_load,
  input  logic             ex_is_store,
  input  logic [2:0]       ex_funct3,
  input  logic             ex_wb_en,
  input  logic [4:0]       ex_rd,
  input  logic             ex_isfloat_rd,
  input  logic             ex_isCSR,
  input  logic [CSR_W-1:0] ex_csr,
  input  logic             ex_isMRET,
  output logic             dm_req,
  output logic [3:0]       dm_we,
  output logic [XLEN-1:0]  dm_addr,
  output logic [XLEN-1:0]  dm_wdata,
  input  logic             dm_gnt,
  input  logic             dm_rvalid,
  input  logic [XLEN-1:0]  dm_rdata,
  output logic             WBctl,
  output logic             isfloat_rd,
  output logic [4:0]       rd,
  output logic [XLEN-1:0]  val3,
  output logic             isCSR_WB,
  output logic [CSR_W-1:0] csr_WB,
  output logic             isMRET_WB,
  output logic [XLEN-1:0]  wb_pc,
  output logic             isinstruct
);

  state_e state_q, state_d;

  logic [XLEN-1:0]  pc_q, result_q, sdata_q, val_q, val_d;
  logic             is_load_q, is_store_q, wb_en_q, isfloat_q, iscsr_q, ismret_q;
  logic [2:0]       funct3_q;
  logic [4:0]       rd_q;
  logic [CSR_W-1:0] csr_q;

  logic             accept, in_wb, in_mreq;
  logic [3:0]       al_we;
  logic [XLEN-1:0]  al_wdata, al_ldata;

  assign ex_ready = (state_q == S_IDLE) || (state_q == S_WB);
  assign accept   = ex_valid && ex_ready;
  assign in_wb    = (state_q == S_WB);
  assign in_mreq  = (state_q == S_MREQ);

  lsu_align #(.XLEN(XLEN)) u_align (
    .addr_lo_i    (result_q[1:0]),
    .funct3_i     (funct3_q),
    .store_data_i (sdata_q),
    .rdata_i      (dm_rdata),
    .we_o         (al_we),
    .wdata_o      (al_wdata),
    .ldata_o      (al_ldata)
  );

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    case (state_q)
      S_IDLE, S_WB: begin
        if (accept) begin
          val_d   = ex_result;
          state_d = (ex_is_load || ex_is_store) ? S_MREQ : S_WB;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MREQ: begin
        if (dm_gnt) begin
          if (is_store_q) begin
            state_d = S_WB;
          end else if (dm_rvalid) begin
            val_d   = al_ldata;
            state_d = S_WB;
          end else begin
            state_d = S_MRESP;
          end
        end
      end
      S_MRESP: begin
        if (dm_rvalid) begin
          val_d   = al_ldata;
          state_d = S_WB;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      val_q      <= '0;
      pc_q       <= '0;
      result_q   <= '0;
      sdata_q    <= '0;
      is_load_q  <= 1'b0;
      is_store_q <= 1'b0;
      funct3_q   <= '0;
      wb_en_q    <= 1'b0;
      rd_q       <= '0;
      isfloat_q  <= 1'b0;
      iscsr_q    <= 1'b0;
      csr_q      <= '0;
      ismret_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      if (accept) begin
        pc_q       <= ex_pc;
        result_q   <= ex_result;
        sdata_q    <= ex_store_data;
        is_load_q  <= ex_is_load;
        is_store_q <= ex_is_store;
        funct3_q   <= ex_funct3;
        wb_en_q    <= ex_wb_en;
        rd_q       <= ex_rd;
        isfloat_q  <= ex_isfloat_rd;
        iscsr_q    <= ex_isCSR;
        csr_q      <= ex_csr;
        ismret_q   <= ex_isMRET;
      end
    end
  end

  // Gating with rst withdraws an in-flight request in the reset cycle itself.
  assign dm_req   = in_mreq && !rst;
  assign dm_we    = (in_mreq && is_store_q) ? al_we : 4'h0;
  assign dm_addr  = in_mreq ? {result_q[XLEN-1:2], 2'b00} : '0;
  assign dm_wdata = (in_mreq && is_store_q) ? al_wdata : '0;

  assign WBctl      = in_wb && wb_en_q && !iscsr_q && !is_store_q && !ismret_q;
  assign isfloat_rd = in_wb && isfloat_q;
  assign rd         = in_wb ? rd_q     : '0;
  assign val3       = in_wb ? val_q    : '0;
  assign isCSR_WB   = in_wb && iscsr_q;
  assign csr_WB     = in_wb ? csr_q    : '0;
  assign isMRET_WB  = in_wb && ismret_q;
  assign wb_pc      = in_wb ? pc_q     : '0;
  assign isinstruct = in_wb;

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
// ============================================================================
//  tb_mem_wb_stage : scoreboard bench for mem_wb_stage with a memory responder
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_pc, ex_result, ex_store_data;
  logic        ex_is_load, ex_is_store, ex_wb_en, ex_isfloat_rd, ex_isCSR, ex_isMRET;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic [3:0]  ex_csr;
  logic        dm_req, dm_gnt, dm_rvalid;
  logic [3:0]  dm_we;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        WBctl, isfloat_rd, isCSR_WB, isMRET_WB, isinstruct;
  logic [4:0]  rd;
  logic [31:0] val3, wb_pc;
  logic [3:0]  csr_WB;

  mem_wb_stage #(.XLEN(32), .CSR_W(4)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_pc(ex_pc), .ex_result(ex_result), .ex_store_data(ex_store_data),
    .ex_is_load(ex_is_load), .ex_is_store(ex_is_store), .ex_funct3(ex_funct3),
    .ex_wb_en(ex_wb_en), .ex_rd(ex_rd), .ex_isfloat_rd(ex_isfloat_rd),
    .ex_isCSR(ex_isCSR), .ex_csr(ex_csr), .ex_isMRET(ex_isMRET),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .WBctl(WBctl), .isfloat_rd(isfloat_rd), .rd(rd), .val3(val3),
    .isCSR_WB(isCSR_WB), .csr_WB(csr_WB), .isMRET_WB(isMRET_WB),
    .wb_pc(wb_pc), .isinstruct(isinstruct)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wbctl;
    logic        isf;
    logic [4:0]  rd;
    logic [31:0] val;
    logic        iscsr;
    logic [3:0]  csr;
    logic        mret;
    logic [31:0] pc;
  } wb_t;

  wb_t   exp_q[$];
  int    n_chk = 0;
  int    n_pass = 0;
  int    cyc = 0;
  int    last_wb_cyc = -10;
  int    prev_wb_cyc = -20;
  int    gnt_delay = 0;
  int    rv_delay = 1;
  logic [31:0] mem_word = 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Reference load extraction: shift the addressed lane down, then extend.
  function automatic logic [31:0] ld_model(input logic [2:0] f3, input logic [1:0] a,
                                            input logic [31:0] w);
    logic [31:0] sb, sh;
    sb = w >> (8 * a);
    sh = w >> (16 * a[1]);
    case (f3)
      3'b000:  return {{24{sb[7]}}, sb[7:0]};
      3'b100:  return {24'h0, sb[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b101:  return {16'h0, sh[15:0]};
      default: return w;
    endcase
  endfunction

  // Memory responder: grant after gnt_delay waiting cycles, read data rv_delay cycles after grant.
  initial begin
    int wait_cnt = 0;
    int rv_cnt = 0;
    dm_gnt = 0; dm_rvalid = 0; dm_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      dm_gnt = 0; dm_rvalid = 0;
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin dm_rvalid = 1; dm_rdata = mem_word; end
      end
      if (!dm_req) wait_cnt = 0;
      else if (wait_cnt >= gnt_delay) begin
        dm_gnt = 1; wait_cnt = 0;
        if (dm_we == 4'h0) begin
          if (rv_delay == 0) begin dm_rvalid = 1; dm_rdata = mem_word; end
          else rv_cnt = rv_delay;
        end
      end else wait_cnt++;
    end
  end

  // Write-back monitor: every retire pulse must match the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst && isinstruct) begin
        prev_wb_cyc = last_wb_cyc;
        last_wb_cyc = cyc;
        if (exp_q.size() == 0) check("wb_unexpected", {31'b0, isinstruct}, 32'h0);
        else begin
          wb_t e;
          e = exp_q.pop_front();
          check("wb_ctl",   {31'b0, WBctl},      {31'b0, e.wbctl});
          check("wb_isf",   {31'b0, isfloat_rd}, {31'b0, e.isf});
          check("wb_rd",    {27'b0, rd},         {27'b0, e.rd});
          check("wb_val3",  val3,                e.val);
          check("wb_iscsr", {31'b0, isCSR_WB},   {31'b0, e.iscsr});
          check("wb_csr",   {28'b0, csr_WB},     {28'b0, e.csr});
          check("wb_mret",  {31'b0, isMRET_WB},  {31'b0, e.mret});
          check("wb_pc",    wb_pc,               e.pc);
        end
      end
    end
  end

  task automatic issue(input logic [31:0] pc, input logic [31:0] res, input logic [31:0] sd,
                       input logic ld, input logic st, input logic [2:0] f3, input logic wen,
                       input logic [4:0] rdi, input logic isf, input logic iscsr,
                       input logic [3:0] csrn, input logic mret, input logic [31:0] expv);
    wb_t e;
    logic rdy, accepted;
    e.wbctl = wen & ~iscsr & ~st & ~mret;
    e.isf = isf; e.rd = rdi; e.val = expv; e.iscsr = iscsr;
    e.csr = csrn; e.mret = mret; e.pc = pc;
    exp_q.push_back(e);
    ex_pc = pc; ex_result = res; ex_store_data = sd; ex_is_load = ld; ex_is_store = st;
    ex_funct3 = f3; ex_wb_en = wen; ex_rd = rdi; ex_isfloat_rd = isf; ex_isCSR = iscsr;
    ex_csr = csrn; ex_isMRET = mret; ex_valid = 1;
    accepted = 0;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clk); rdy = ex_ready;
      @(posedge clk); #1; accepted = rdy;
    end
    if (!accepted) check("accept_timeout", {31'b0, accepted}, 32'h1);
    ex_valid = 0;
  endtask

  task automatic alu(input logic [31:0] pc, input logic [4:0] rdi, input logic [31:0] res);
    issue(pc, res, 32'h0, 0, 0, 3'b000, 1, rdi, 0, 0, 4'h0, 0, res);
  endtask

  task automatic load(input logic [31:0] pc, input logic [2:0] f3, input logic [31:0] a,
                      input logic [4:0] rdi, input logic isf);
    issue(pc, a, 32'h0, 1, 0, f3, 1, rdi, isf, 0, 4'h0, 0, ld_model(f3, a[1:0], mem_word));
  endtask

  initial begin
    int reqs;
    rst = 1; ex_valid = 0; ex_pc = 0; ex_result = 0; ex_store_data = 0;
    ex_is_load = 0; ex_is_store = 0; ex_funct3 = 0; ex_wb_en = 0; ex_rd = 0;
    ex_isfloat_rd = 0; ex_isCSR = 0; ex_csr = 0; ex_isMRET = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ex_ready", {31'b0, ex_ready}, 32'h1);
    check("rst_dm_req",   {31'b0, dm_req},   32'h0);
    check("rst_retire",   {31'b0, isinstruct}, 32'h0);
    check("rst_val3",     val3, 32'h0);
    @(posedge clk); #1 rst = 0;

    // ALU op: retires exactly one cycle after acceptance
    alu(32'h100, 5'd5, 32'h1234);
    @(negedge clk);
    check("add_latency", {31'b0, isinstruct}, 32'h1);
    check("add_wbctl",   {31'b0, WBctl}, 32'h1);
    repeat (2) @(posedge clk); #1;

    // back-to-back ALU ops retire on consecutive cycles
    alu(32'h104, 5'd6, 32'h1);
    alu(32'h108, 5'd7, 32'h2);
    @(negedge clk);
    check("b2b_ready", {31'b0, ex_ready}, 32'h1);
    check("b2b_consecutive", last_wb_cyc - prev_wb_cyc, 32'd1);
    repeat (2) @(posedge clk); #1;

    // SB to byte 3 with grant after two wait cycles
    gnt_delay = 2;
    issue(32'h10C, 32'h103, 32'hAB, 0, 1, 3'b000, 0, 5'd0, 0, 0, 4'h0, 0, 32'h103);
    reqs = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!dm_req) break;
      reqs++;
      check("sb_we", {28'b0, dm_we}, 32'h8);
      check("sb_wdata", dm_wdata, 32'hABABABAB);
      check("sb_addr", dm_addr, 32'h100);
    end
    check("sb_req_cycles", reqs, 32'd3);
    gnt_delay = 0;
    repeat (2) @(posedge clk); #1;

    // SH to upper half
    issue(32'h110, 32'h202, 32'h12345678, 0, 1, 3'b001, 0, 5'd0, 0, 0, 4'h0, 0, 32'h202);
    @(negedge clk);
    check("sh_we", {28'b0, dm_we}, 32'hC);
    check("sh_wdata", dm_wdata, 32'h56785678);
    repeat (3) @(posedge clk); #1;

    // loads with a one-cycle read latency
    rv_delay = 1;
    mem_word = 32'h0080_0000; load(32'h114, 3'b000, 32'h102, 5'd8, 0);
    repeat (4) @(posedge clk); #1;
    mem_word = 32'h8001_0000; load(32'h118, 3'b101, 32'h102, 5'd9, 0);
    repeat (4) @(posedge clk); #1;
    mem_word = 32'h0000_8765; load(32'h11C, 3'b001, 32'h100, 5'd10, 0);
    repeat (4) @(posedge clk); #1;
    mem_word = 32'h0000_F200; load(32'h120, 3'b100, 32'h101, 5'd11, 0);
    repeat (4) @(posedge clk); #1;
    mem_word = 32'h3F80_0000; load(32'h124, 3'b010, 32'h203, 5'd12, 1);
    repeat (4) @(posedge clk); #1;

    // LW with grant and read data in the same cycle
    rv_delay = 0; mem_word = 32'hDEADBEEF;
    load(32'h128, 3'b010, 32'h300, 5'd13, 0);
    @(negedge clk);
    check("lw_same_req", {31'b0, dm_req}, 32'h1);
    @(negedge clk);
    check("lw_same_wb", {31'b0, isinstruct}, 32'h1);
    repeat (2) @(posedge clk); #1;

    // CSR write and MRET
    issue(32'h12C, 32'h80, 32'h0, 0, 0, 3'b001, 1, 5'd3, 0, 1, 4'd4, 0, 32'h80);
    repeat (2) @(posedge clk); #1;
    issue(32'h130, 32'h0, 32'h0, 0, 0, 3'b000, 0, 5'd0, 0, 0, 4'h0, 1, 32'h0);
    repeat (2) @(posedge clk); #1;

    // reset while the request is pending drops it in the same cycle
    gnt_delay = 10;
    load(32'h134, 3'b010, 32'h400, 5'd14, 0);
    @(negedge clk);
    check("mreq_req", {31'b0, dm_req}, 32'h1);
    @(posedge clk); #1 rst = 1;
    @(negedge clk);
    check("mreq_rst_drop", {31'b0, dm_req}, 32'h0);
    @(posedge clk); #1 rst = 0;
    void'(exp_q.pop_back());
    @(negedge clk);
    check("mreq_rst_idle", {31'b0, dm_req}, 32'h0);

    // reset while waiting for read data; the late rvalid must not retire
    gnt_delay = 0; rv_delay = 4;
    @(posedge clk); #1;
    load(32'h138, 3'b010, 32'h500, 5'd15, 0);
    @(posedge clk); #1 rst = 1;
    @(negedge clk);
    check("mresp_rst_req", {31'b0, dm_req}, 32'h0);
    @(posedge clk); #1 rst = 0;
    void'(exp_q.pop_back());
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("late_rvalid_wb", {31'b0, isinstruct}, 32'h0);
    end

    // drain and make sure every expected write-back was observed
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
